// File: rtl/crc_serial_framer.sv
// Bit-serial CRC framer: streams a parallel message word MSB-first,
// then appends its CRC remainder MSB-first, under valid/ready backpressure.
module crc_serial_framer #(
    parameter int               MSG_W = 6,
    parameter int               CRC_W = 5,
    parameter logic [CRC_W-1:0] POLY  = 5'b00101,
    parameter logic [CRC_W-1:0] INIT  = 5'b00000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MSG_W-1:0] msg_in,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic [CRC_W-1:0] crc_out,
    output logic             crc_done,
    output logic             busy
);

    localparam int MAX_W = (MSG_W > CRC_W) ? MSG_W : CRC_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_W - 1);
    localparam logic [CNT_W-1:0] CRC_PEN  = CNT_W'(CRC_W - 2);

    typedef enum logic [1:0] {
        IDLE,
        MSG,
        CRC
    } state_t;

    state_t           state;
    logic [MSG_W-1:0] shreg;
    logic [CRC_W-1:0] lfsr;
    logic [CRC_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;

    logic             xfer;
    logic             fb;
    logic [CRC_W-1:0] lfsr_nxt;
    logic [MSG_W-1:0] sh_nxt;
    logic [CRC_W-1:0] shadow_nxt;

    // Next LFSR/shift values for the bit being handed off this cycle
    always_comb begin
        xfer       = ser_valid && ser_ready;
        fb         = lfsr[CRC_W-1] ^ ser_bit;
        lfsr_nxt   = (lfsr << 1) ^ (fb ? POLY : '0);
        sh_nxt     = shreg << 1;
        shadow_nxt = shadow << 1;
    end

    // Frame sequencer with registered handshake and serial outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            lfsr      <= INIT;
            shadow    <= '0;
            cnt       <= '0;
            msg_ready <= 1'b1;
            ser_valid <= 1'b0;
            ser_bit   <= 1'b0;
            ser_last  <= 1'b0;
            crc_out   <= '0;
            crc_done  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            crc_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (msg_valid) begin
                        state     <= MSG;
                        shreg     <= msg_in;
                        lfsr      <= INIT;
                        cnt       <= '0;
                        msg_ready <= 1'b0;
                        busy      <= 1'b1;
                        ser_valid <= 1'b1;
                        ser_bit   <= msg_in[MSG_W-1];
                        ser_last  <= 1'b0;
                    end
                end
                MSG: begin
                    if (xfer) begin
                        lfsr  <= lfsr_nxt;
                        shreg <= sh_nxt;
                        if (cnt == MSG_LAST) begin
                            state   <= CRC;
                            cnt     <= '0;
                            crc_out <= lfsr_nxt;
                            shadow  <= lfsr_nxt;
                            ser_bit <= lfsr_nxt[CRC_W-1];
                        end else begin
                            cnt     <= cnt + 1'b1;
                            ser_bit <= sh_nxt[MSG_W-1];
                        end
                    end
                end
                CRC: begin
                    if (xfer) begin
                        shadow <= shadow_nxt;
                        if (cnt == CRC_LAST) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            ser_valid <= 1'b0;
                            ser_bit   <= 1'b0;
                            ser_last  <= 1'b0;
                            crc_done  <= 1'b1;
                            msg_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            ser_bit  <= shadow_nxt[CRC_W-1];
                            ser_last <= (cnt == CRC_PEN);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/crc_serial_framer.md
Name: crc_serial_framer

Overview:
- Sequencer around the bit-serial CRC LFSR datapath.
- Accepts one parallel message word per frame over a valid/ready handshake.
- Shifts the word MSB-first through the CRC-CRC_W LFSR while streaming it out bit-serially with backpressure, then appends the computed remainder MSB-first to form the codeword.
- Sits between the parallel message source and the serial line driver; also exposes the remainder in parallel.

Parameters:
- MSG_W, 6, message width in bits (≥1).
- CRC_W, 5, CRC width in bits (≥2).
- POLY, 5'b00101, generator polynomial without the implicit x^CRC_W term (default G = x^5+x^2+1).
- INIT, 5'b00000, LFSR preset loaded at each frame start.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- msg_in, input, MSG_W, message word; bit MSG_W-1 is sent first.
- msg_valid, input, 1, message word is present.
- msg_ready, output, 1, framer can accept a word (high only in IDLE).
- ser_bit, output, 1, current serial codeword bit.
- ser_valid, output, 1, ser_bit is valid.
- ser_ready, input, 1, sink accepts ser_bit this cycle.
- ser_last, output, 1, ser_bit is the final codeword bit.
- crc_out, output, CRC_W, remainder of the last completed frame.
- crc_done, output, 1, one-cycle pulse when a frame completes.
- busy, output, 1, a frame is in progress (state ≠ IDLE).

Behaviour:
- Clock and reset: single clock domain; asynchronous active-high reset.
- Reset values: state = IDLE, msg_ready = 1, ser_valid = 0, ser_bit = 0, ser_last = 0, crc_out = 0, crc_done = 0, busy = 0, LFSR = INIT, bit counter = 0.
- States:
  - IDLE: on msg_valid && msg_ready, latch msg_in into the shift register, load the LFSR with INIT, clear the counter, go to MSG.
  - MSG: ser_valid = 1; ser_bit = shreg[MSG_W-1].
    - On each transfer (ser_valid && ser_ready): fb = lfsr[CRC_W-1] ^ ser_bit; lfsr <= {lfsr[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0); shreg shifts left; counter increments.
    - After the MSG_W-th transfer: go to CRC and copy the LFSR result into crc_out.
  - CRC: ser_valid = 1; ser_bit = crc_out-shadow MSB; the shadow shifts left on each transfer; ser_last = 1 while presenting bit 0.
    - After the CRC_W-th transfer: go to IDLE and pulse crc_done for one cycle.
- The LFSR computes M(x)·x^CRC_W mod G(x) directly; no zero-flush cycles are needed.
- Latency:
  - Word accepted at cycle T; first ser_valid at T+1.
  - With ser_ready held at 1, the frame occupies exactly MSG_W+CRC_W cycles, with the final transfer at T+MSG_W+CRC_W.
  - crc_done and msg_ready are asserted in cycle T+MSG_W+CRC_W+1.
- Handshake:
  - ser_bit, ser_last and ser_valid are registered.
  - While ser_valid && !ser_ready, ser_bit and ser_last stay stable and no LFSR update occurs.
  - The output stream has no gaps while ser_ready = 1.
- Back-to-back frames: no new word is accepted until IDLE, so there is at least one idle cycle between frames; msg_valid outside IDLE is ignored.
- crc_out holds its value until the next frame's last message-bit transfer; it is never cleared except by reset.
- Reset mid-frame: immediate abort to the reset values; no crc_done; the partial frame is discarded.
- Simultaneous events: the crc_done cycle is IDLE, so a msg_valid in that cycle is accepted.

Test Plan:
- Reset asserted, then msg_in = 6'b111001 with msg_valid and ser_ready = 1 -> serial stream 1,1,1,0,0,1,0,0,0,1,1 on 11 consecutive cycles; ser_last on the 11th; crc_out = 5'b00011; crc_done one cycle later.
- msg_in = 6'b101011, ser_ready = 1 -> codeword 101011_10011; crc_out = 5'b10011.
- msg_in = 6'b000000 -> codeword of eleven 0s; crc_out = 5'b00000; crc_done pulses.
- Frame 111001 with ser_ready toggled 1,0,0,1,... -> the same 11-bit sequence; ser_bit stable during stalls; crc_done only after the 11th accepted bit; busy high throughout.
- msg_valid held high continuously -> frames 111001 then 101011 with exactly one IDLE cycle between; the second word is accepted in the crc_done cycle; msg_valid asserted mid-frame is ignored.
- reset asserted after the 4th serial transfer -> all outputs return to reset values asynchronously; no crc_done; the next frame 111001 still yields 5'b00011.
